pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have parameter PC_W, default 12, program-counter width.
REQ-002 The block SHALL have parameter LABEL_W, default 8, branch-label width.
REQ-003 The block SHALL have parameter CNT_W, default 16, cycle-counter width.
REQ-004 Ports (name, direction, width, meaning), clock and reset first:
- clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  begin a program run.
- start_label  in  LABEL_W  label whose target is the entry PC.
- stall  in  1  hold the PC this cycle.
- halt  in  1  current instruction is a halt.
- branch_en  in  1  current instruction is a branch.
- branch_taken  in  1  branch condition true.
- branch_label  in  LABEL_W  branch target label.
- pc  out  PC_W  current fetch address.
- fetch_valid  out  1  pc is a valid fetch this cycle.
- busy  out  1  in RUN.
- done  out  1  one-cycle completion pulse.
- fault  out  1  sticky invalid-label flag.
- cycle_cnt  out  CNT_W  RUN cycles of the last or current run.

Function
REQ-005 The block SHALL implement states IDLE, RUN, DONE and FAULT.
REQ-006 The block SHALL map each label combinationally to a PC_W target through the fixed table:
- 0→2, 1→2, 2→325, 3→203, 4→214, 5→225, 6→236, 7→247, 8→258, 9→269, 10→280, 11→290
- 12→300, 13→310, 14→317, 15→451, 16→460, 17→620, 18→6, 19→20, 20→35, 21→50
- 22→65, 23→82, 24→92, 25→109, 26→127, 27→145, 28→160, 29→177, 30→201, 31→216
- 32→233, 33→250, 34→254, 35→276, 36→295, 37→314, 38→333, 39→353, 40→372, 41→391, 42→410, 43→435
- Any label above 43 SHALL be invalid, with target 0.
REQ-007 In IDLE or FAULT, start with a valid start_label SHALL load pc with the target, clear cycle_cnt, clear fault, and move to RUN on the next edge.
REQ-008 In IDLE or FAULT, start with an invalid start_label SHALL set fault, leave pc at 0, and enter FAULT.
REQ-009 In RUN, fetch_valid and busy SHALL be 1, and cycle_cnt SHALL increment every cycle, including stall cycles, saturating at all-ones.
REQ-010 In RUN, the next-PC priority SHALL be: halt → DONE with pc held; else stall → pc held; else taken branch → pc=target; else pc=pc+1, wrapping 2^PC_W−1→0.
REQ-011 A taken branch with an invalid branch_label SHALL enter FAULT, set fault, and hold pc.
REQ-012 branch_taken SHALL be ignored when branch_en=0.
REQ-013 halt SHALL take priority over stall and branch when they are simultaneous.
REQ-014 start SHALL be ignored in RUN and DONE.
REQ-015 DONE SHALL last exactly one cycle with done=1 and fetch_valid=0, then go to IDLE.
REQ-016 pc and cycle_cnt SHALL hold their last values in IDLE, DONE and FAULT.
REQ-017 Latency SHALL be one cycle: inputs sampled at edge N are reflected on pc at edge N+1.

Reset
REQ-018 On a reset-high edge: state=IDLE, pc=0, fetch_valid=0, busy=0, done=0, fault=0, cycle_cnt=0.
REQ-019 Reset SHALL take priority over every other input, including mid-RUN, and SHALL abort a run with no done pulse.

Structure
REQ-020 A shared package SHALL hold the state enum, PC_W, LABEL_W, CNT_W, and LABEL_MAX=43.
REQ-021 The label-to-target table SHALL be a separate combinational sub-module, branch_target_table, with a valid output, instantiated twice (start and branch) or once behind a mux.

Verification
REQ-022 Start, start_label=18, no stall, halt asserted on the 4th RUN cycle → pc 6,7,8,9 with pc held at 9, done pulses 1 cycle, cycle_cnt=4, then IDLE.
REQ-023 In RUN at pc=10, branch_en=1, taken=1, label=17 → next pc=620; with taken=0 → next pc=11.
REQ-024 Taken branch with label=44 → fault=1, FAULT, pc held; a subsequent start with label 3 → pc=203, fault=0.
REQ-025 stall=1 for 3 cycles at pc=35 → pc stays 35, cycle_cnt increases by 3; halt+branch+stall in the same cycle → DONE, pc held.
REQ-026 Reset asserted mid-RUN at pc=300 → next cycle pc=0, IDLE, busy=0, done never pulses.
REQ-027 Force pc=4095 via a hierarchical deposit, then a plain advance → pc=0, fetch_valid stays 1.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// Shared types and sizing for the program-counter sequencer.
package pc_sequencer_pkg;

  localparam int unsigned PC_W      = 12;
  localparam int unsigned LABEL_W   = 8;
  localparam int unsigned CNT_W     = 16;
  localparam int unsigned LABEL_MAX = 43;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DONE  = 2'd2,
    FAULT = 2'd3
  } state_e;

endpackage

// File: rtl/branch_target_table.sv
// Fixed label-to-PC lookup; labels above LABEL_MAX are invalid and map to 0.
module branch_target_table
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned TBL_PC_W    = pc_sequencer_pkg::PC_W,
  parameter int unsigned TBL_LABEL_W = pc_sequencer_pkg::LABEL_W
) (
  input  logic [TBL_LABEL_W-1:0] label,
  output logic [TBL_PC_W-1:0]    target_c,
  output logic                   valid_c
);

  logic [31:0] lbl;
  logic [31:0] tgt;

  always_comb begin
    lbl     = 32'(label);
    tgt     = 32'd0;
    valid_c = (lbl <= LABEL_MAX);
    case (lbl)
      0, 1:    tgt = 32'd2;
      2:       tgt = 32'd325;
      3:       tgt = 32'd203;
      4:       tgt = 32'd214;
      5:       tgt = 32'd225;
      6:       tgt = 32'd236;
      7:       tgt = 32'd247;
      8:       tgt = 32'd258;
      9:       tgt = 32'd269;
      10:      tgt = 32'd280;
      11:      tgt = 32'd290;
      12:      tgt = 32'd300;
      13:      tgt = 32'd310;
      14:      tgt = 32'd317;
      15:      tgt = 32'd451;
      16:      tgt = 32'd460;
      17:      tgt = 32'd620;
      18:      tgt = 32'd6;
      19:      tgt = 32'd20;
      20:      tgt = 32'd35;
      21:      tgt = 32'd50;
      22:      tgt = 32'd65;
      23:      tgt = 32'd82;
      24:      tgt = 32'd92;
      25:      tgt = 32'd109;
      26:      tgt = 32'd127;
      27:      tgt = 32'd145;
      28:      tgt = 32'd160;
      29:      tgt = 32'd177;
      30:      tgt = 32'd201;
      31:      tgt = 32'd216;
      32:      tgt = 32'd233;
      33:      tgt = 32'd250;
      34:      tgt = 32'd254;
      35:      tgt = 32'd276;
      36:      tgt = 32'd295;
      37:      tgt = 32'd314;
      38:      tgt = 32'd333;
      39:      tgt = 32'd353;
      40:      tgt = 32'd372;
      41:      tgt = 32'd391;
      42:      tgt = 32'd410;
      43:      tgt = 32'd435;
      default: tgt = 32'd0;
    endcase
    target_c = TBL_PC_W'(tgt);
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: start/run/halt control with labelled branches,
// one shared target table muxed between the start label and branch label.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned PC_W    = pc_sequencer_pkg::PC_W,
  parameter int unsigned LABEL_W = pc_sequencer_pkg::LABEL_W,
  parameter int unsigned CNT_W   = pc_sequencer_pkg::CNT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [LABEL_W-1:0] start_label,
  input  logic               stall,
  input  logic               halt,
  input  logic               branch_en,
  input  logic               branch_taken,
  input  logic [LABEL_W-1:0] branch_label,
  output logic [PC_W-1:0]    pc,
  output logic               fetch_valid,
  output logic               busy,
  output logic               done,
  output logic               fault,
  output logic [CNT_W-1:0]   cycle_cnt
);

  state_e             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               fault_q, fault_d;
  logic               fetch_valid_q, fetch_valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [LABEL_W-1:0] sel_label;
  logic [PC_W-1:0]    tbl_target;
  logic               tbl_valid;

  // Only RUN looks at branch labels; otherwise the table serves the start label.
  assign sel_label = (state_q == RUN) ? branch_label : start_label;

  branch_target_table #(
    .TBL_PC_W    (PC_W),
    .TBL_LABEL_W (LABEL_W)
  ) u_tbl (
    .label    (sel_label),
    .target_c (tbl_target),
    .valid_c  (tbl_valid)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    fault_d = fault_q;
    case (state_q)
      IDLE, FAULT: begin
        if (start) begin
          pc_d = tbl_target;
          if (tbl_valid) begin
            cnt_d   = '0;
            fault_d = 1'b0;
            state_d = RUN;
          end else begin
            fault_d = 1'b1;
            state_d = FAULT;
          end
        end
      end
      RUN: begin
        if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
        if (halt) begin
          state_d = DONE;
        end else if (stall) begin
          pc_d = pc_q;
        end else if (branch_en && branch_taken) begin
          if (tbl_valid) begin
            pc_d = tbl_target;
          end else begin
            fault_d = 1'b1;
            state_d = FAULT;
          end
        end else begin
          pc_d = pc_q + PC_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    fetch_valid_d = (state_d == RUN);
    busy_d        = (state_d == RUN);
    done_d        = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      pc_q          <= '0;
      cnt_q         <= '0;
      fault_q       <= 1'b0;
      fetch_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      cnt_q         <= cnt_d;
      fault_q       <= fault_d;
      fetch_valid_q <= fetch_valid_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign pc          = pc_q;
  assign fetch_valid = fetch_valid_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign fault       = fault_q;
  assign cycle_cnt   = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer with hand-computed expectations.
module tb_pc_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  start_label;
  logic        stall;
  logic        halt;
  logic        branch_en;
  logic        branch_taken;
  logic [7:0]  branch_label;
  logic [11:0] pc;
  logic        fetch_valid;
  logic        busy;
  logic        done;
  logic        fault;
  logic [15:0] cycle_cnt;

  int n_cmp;
  int n_err;

  pc_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .start_label  (start_label),
    .stall        (stall),
    .halt         (halt),
    .branch_en    (branch_en),
    .branch_taken (branch_taken),
    .branch_label (branch_label),
    .pc           (pc),
    .fetch_valid  (fetch_valid),
    .busy         (busy),
    .done         (done),
    .fault        (fault),
    .cycle_cnt    (cycle_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle 1ns past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    start        = 1'b0;
    start_label  = 8'd0;
    stall        = 1'b0;
    halt         = 1'b0;
    branch_en    = 1'b0;
    branch_taken = 1'b0;
    branch_label = 8'd0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    clear_inputs();
    step(2);
    reset = 1'b0;
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_fv", 32'(fetch_valid), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_cnt", 32'(cycle_cnt), 32'd0);

    // Label 18 -> pc 6; halt on the 4th RUN cycle.
    start = 1'b1; start_label = 8'd18;
    step(1);
    check("run_pc6", 32'(pc), 32'd6);
    check("run_busy", 32'(busy), 32'd1);
    check("run_fv", 32'(fetch_valid), 32'd1);
    start_label = 8'd3;
    step(1);
    check("start_ign_run", 32'(pc), 32'd7);
    start = 1'b0;
    step(2);
    check("run_pc9", 32'(pc), 32'd9);
    check("run_cnt3", 32'(cycle_cnt), 32'd3);
    halt = 1'b1;
    step(1);
    halt = 1'b0;
    check("done_pulse", 32'(done), 32'd1);
    check("done_fv", 32'(fetch_valid), 32'd0);
    check("done_pc", 32'(pc), 32'd9);
    check("done_cnt", 32'(cycle_cnt), 32'd4);
    start = 1'b1; start_label = 8'd3;
    step(1);
    start = 1'b0;
    check("done_one_cyc", 32'(done), 32'd0);
    check("start_ign_done", 32'(busy), 32'd0);
    check("idle_pc", 32'(pc), 32'd9);
    check("idle_cnt", 32'(cycle_cnt), 32'd4);

    // Not-taken and disabled branches at pc 10.
    start = 1'b1; start_label = 8'd18;
    step(1);
    start = 1'b0;
    check("rerun_cnt0", 32'(cycle_cnt), 32'd0);
    step(4);
    check("at_pc10", 32'(pc), 32'd10);
    branch_en = 1'b1; branch_taken = 1'b0; branch_label = 8'd17;
    step(1);
    check("br_not_taken", 32'(pc), 32'd11);
    branch_en = 1'b0; branch_taken = 1'b1;
    step(1);
    check("br_disabled", 32'(pc), 32'd12);
    branch_taken = 1'b0;
    halt = 1'b1;
    step(1);
    halt = 1'b0;
    step(1);

    // Taken branch at pc 10, then run up to the PC wrap.
    start = 1'b1; start_label = 8'd18;
    step(1);
    start = 1'b0;
    step(4);
    branch_en = 1'b1; branch_taken = 1'b1; branch_label = 8'd17;
    step(1);
    branch_en = 1'b0; branch_taken = 1'b0;
    check("br_taken", 32'(pc), 32'd620);
    check("br_cnt", 32'(cycle_cnt), 32'd5);
    step(3475);
    check("pc_max", 32'(pc), 32'd4095);
    step(1);
    check("pc_wrap", 32'(pc), 32'd0);
    check("wrap_fv", 32'(fetch_valid), 32'd1);
    check("wrap_cnt", 32'(cycle_cnt), 32'd3481);
    step(1);

    // Invalid branch label faults and holds pc 1.
    branch_en = 1'b1; branch_taken = 1'b1; branch_label = 8'd44;
    step(1);
    branch_en = 1'b0; branch_taken = 1'b0;
    check("bad_br_fault", 32'(fault), 32'd1);
    check("bad_br_pc", 32'(pc), 32'd1);
    check("bad_br_busy", 32'(busy), 32'd0);
    check("bad_br_cnt", 32'(cycle_cnt), 32'd3483);
    step(2);
    check("fault_sticky", 32'(fault), 32'd1);
    check("fault_pc_hold", 32'(pc), 32'd1);
    start = 1'b1; start_label = 8'd3;
    step(1);
    start = 1'b0;
    check("recover_pc", 32'(pc), 32'd203);
    check("recover_fault", 32'(fault), 32'd0);
    check("recover_busy", 32'(busy), 32'd1);

    // Stall three cycles at pc 35, then halt+branch+stall together.
    branch_en = 1'b1; branch_taken = 1'b1; branch_label = 8'd20;
    step(1);
    branch_en = 1'b0; branch_taken = 1'b0;
    check("br_pc35", 32'(pc), 32'd35);
    check("br_cnt1", 32'(cycle_cnt), 32'd1);
    stall = 1'b1;
    step(3);
    check("stall_pc", 32'(pc), 32'd35);
    check("stall_cnt", 32'(cycle_cnt), 32'd4);
    halt = 1'b1; branch_en = 1'b1; branch_taken = 1'b1; branch_label = 8'd17;
    step(1);
    clear_inputs();
    check("prio_done", 32'(done), 32'd1);
    check("prio_pc", 32'(pc), 32'd35);
    step(1);

    // Reset mid-run at pc 300 aborts without a done pulse.
    start = 1'b1; start_label = 8'd12;
    step(1);
    start = 1'b0;
    check("pc300", 32'(pc), 32'd300);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check("mid_rst_pc", 32'(pc), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_cnt", 32'(cycle_cnt), 32'd0);
    step(1);
    check("post_rst_done", 32'(done), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);

    // Invalid start label from IDLE, then recovery with label 0.
    start = 1'b1; start_label = 8'd200;
    step(1);
    start = 1'b0;
    check("bad_start_fault", 32'(fault), 32'd1);
    check("bad_start_pc", 32'(pc), 32'd0);
    check("bad_start_busy", 32'(busy), 32'd0);
    start = 1'b1; start_label = 8'd0;
    step(1);
    start = 1'b0;
    check("lbl0_pc", 32'(pc), 32'd2);
    check("lbl0_fault", 32'(fault), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
